uart_core: RTL
==============

Name: uart_core

Overview:
- Parametrised full-duplex UART that succeeds the fixed 8N1 block.
- Configurable data width, parity and stop bits; valid/ready TX handshake; 16x-oversampled RX with majority voting; per-frame error flags.
- Sits between the host-side byte interface (debug console, command parser) and the board pins tx/rx.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame, legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- OS_DIV, (CLK_FREQ+8*BAUD)/(16*BAUD), clocks per 16x tick (27 at defaults). Derived; do not override.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- tx_data, input, DATA_BITS, byte to send; sampled on handshake.
- tx_valid, input, 1, tx_data valid.
- tx_ready, output, 1, TX idle; handshake completes when tx_valid && tx_ready.
- tx, output, 1, serial out, idle high.
- rx, input, 1, serial in, asynchronous to clk.
- rx_data, output, DATA_BITS, last received data.
- rx_valid, output, 1, one-cycle pulse per completed frame.
- rx_frame_err, output, 1, qualifies rx_valid: a stop bit sampled 0.
- rx_parity_err, output, 1, qualifies rx_valid: parity mismatch (always 0 when PARITY=0).

Behaviour:
- Reset: one clock, reset asynchronous active-high.
  - During reset: tx=1, tx_ready=0.
  - First clock after rst deasserts: tx_ready=1.
  - rx_data=0; rx_valid, rx_frame_err and rx_parity_err all 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame immediately; no partial output.
- Tick generator:
  - Counter 0..OS_DIV-1 with a sync clear; tick pulses when count==OS_DIV-1.
  - One bit = 16 ticks = 16*OS_DIV clocks.
  - TX and RX each own an instance, cleared at frame start, so bit timing is phase-exact.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: tx_ready=1, tx=1.
  - On handshake: latch tx_data, clear TX tick gen, drop tx_ready, enter START. tx goes 0 on the next clock.
  - Each state holds tx for exactly 16 ticks.
  - DATA sends LSB first, DATA_BITS bits.
  - PARITY bit: even = XOR of data; odd = its inverse.
  - STOP holds tx=1 for STOP_BITS*16 ticks.
  - Return to IDLE: tx_ready rises; back-to-back frames have no extra idle gap.
  - tx_valid while not ready is ignored (held by the source).
- RX:
  - rx passes through a 2-flop synchroniser.
  - FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE; plus WAIT_HIGH.
  - IDLE: synchronised rx low clears the RX tick gen and enters START.
  - Every bit is voted 2-of-3 over samples at ticks 7, 8 and 9 of that bit.
  - START: vote=1 is a false start; return to IDLE, no output.
  - DATA: shift in LSB first.
  - PARITY: compare with computed parity; mismatch sets the parity error.
  - STOP: vote each of STOP_BITS stop bits.
- RX output: at tick 9 of the last stop bit, drive rx_valid for 1 clock with rx_data and both error flags.
  - Data is delivered even when an error flag is set.
  - Error flags hold their value until the next rx_valid.
  - No RX back-pressure. The consumer must take rx_data while rx_valid is high; rx_data is stable until the next rx_valid.
- Framing error path: if any stop bit votes 0, go to WAIT_HIGH after output and stay until synchronised rx=1.
  - Prevents a break condition from retriggering.
- Resynchronisation: the remainder of a stop bit after tick 9 overlaps IDLE, so the next start edge is accepted.
- Full duplex: TX and RX are fully independent.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1:
  - RX synchroniser input is taken from the internal tx;
  - pin tx is forced to 1.
  - Switch only while both FSMs are idle; switching otherwise is undefined.
- Undefined: no loopback port; RX is always driven from pin rx.

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - TX and RX state encodings;
  - OS_RATE=16 and sample tick constants 7, 8, 9;
  - function computing OS_DIV from CLK_FREQ and BAUD.
- Sub-module uart_tick_gen: parameter DIV; ports clk, rst, clr, tick. Instantiated once for TX and once for RX.

Test Plan:
- Defaults, send 0xA5 -> tx low for 432 clocks, then bits 1,0,1,0,0,1,0,1 of 432 clocks each, then high; tx_ready low throughout, high after the stop bit.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, loop tx to rx, send 0x41 -> frame length 11*432 clocks; rx_valid pulses once with rx_data=0x41 and both error flags 0.
- Drive rx frame 0x3C with the parity bit inverted (PARITY=1) -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- Drive rx low for 10 bit times (break) -> one rx_valid with rx_data=0x00 and rx_frame_err=1; no further rx_valid until rx high and a new start bit arrives.
- Glitch rx low for 100 clocks -> false start; no rx_valid; next valid frame 0x55 received correctly.
- Assert rst mid-DATA of a TX frame 0xFF -> tx=1 immediately; tx_ready=1 on the first clock after deassert; next frame 0x12 is sent intact. With UART_LOOPBACK_EN, loopback=1 -> 0x12 is received, pin tx stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM encodings and the oversampling divider
//            helper for the parametrised UART core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OS_RATE   = 16;
    localparam int SAMPLE_T0 = 7;
    localparam int SAMPLE_T1 = 8;
    localparam int SAMPLE_T2 = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Rounded clocks per oversampling tick.
    function automatic int calc_os_div(input int clk_freq, input int baud);
        return (clk_freq + (OS_RATE / 2) * baud) / (OS_RATE * baud);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
// Module   : uart_tick_gen
// Brief    : Free-running 16x oversampling tick divider with synchronous
//            clear so each frame starts on an exact tick phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// ============================================================================
// Module   : uart_core
// Brief    : Parametrised full-duplex UART: valid/ready TX, 16x-oversampled
//            RX with 2-of-3 voting and per-frame error flags.
//            Optional internal loopback when UART_LOOPBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OS_DIV    = calc_os_div(CLK_FREQ, BAUD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);

    localparam logic [3:0] C_LAST_TICK = 4'(OS_RATE - 1);
    localparam logic [2:0] C_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] C_LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       C_ODD       = (PARITY == PAR_ODD);
    localparam logic       C_HAS_PAR   = (PARITY != PAR_NONE);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            r_tx_state;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic [3:0]           r_tx_tick_cnt;
    logic [2:0]           r_tx_bit_idx;
    logic                 w_tx_tick;
    logic                 w_tx_hs;
    logic                 w_tx_bit_end;

    assign w_tx_hs      = tx_valid && r_tx_ready && (r_tx_state == TX_IDLE);
    assign w_tx_bit_end = w_tx_tick && (r_tx_tick_cnt == C_LAST_TICK);
    assign tx_ready     = r_tx_ready;

    uart_tick_gen #(.DIV(OS_DIV)) u_tx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tx_hs),
        .tick (w_tx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state    <= TX_IDLE;
            r_tx          <= 1'b1;
            r_tx_ready    <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx_tick_cnt <= '0;
            r_tx_bit_idx  <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    if (w_tx_hs) begin
                        r_tx_shift    <= tx_data;
                        r_tx_par      <= (^tx_data) ^ C_ODD;
                        r_tx_tick_cnt <= '0;
                        r_tx_ready    <= 1'b0;
                        r_tx          <= 1'b0;
                        r_tx_state    <= TX_START;
                    end
                end
                TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
                    end
                    if (w_tx_bit_end) begin
                        case (r_tx_state)
                            TX_START: begin
                                r_tx         <= r_tx_shift[0];
                                r_tx_bit_idx <= '0;
                                r_tx_state   <= TX_DATA;
                            end
                            TX_DATA: begin
                                if (r_tx_bit_idx == C_LAST_DATA) begin
                                    r_tx_bit_idx <= '0;
                                    if (C_HAS_PAR) begin
                                        r_tx       <= r_tx_par;
                                        r_tx_state <= TX_PARITY;
                                    end else begin
                                        r_tx       <= 1'b1;
                                        r_tx_state <= TX_STOP;
                                    end
                                end else begin
                                    r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
                                    r_tx_shift   <= r_tx_shift >> 1;
                                    r_tx         <= r_tx_shift[1];
                                end
                            end
                            TX_PARITY: begin
                                r_tx         <= 1'b1;
                                r_tx_bit_idx <= '0;
                                r_tx_state   <= TX_STOP;
                            end
                            default: begin
                                if (r_tx_bit_idx == C_LAST_STOP) begin
                                    r_tx_ready <= 1'b1;
                                    r_tx_state <= TX_IDLE;
                                end else begin
                                    r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pin / loopback routing
    // ------------------------------------------------------------------
    logic w_rx_in;

`ifdef UART_LOOPBACK_EN
    assign w_rx_in = loopback ? r_tx : rx;
    assign tx      = loopback ? 1'b1 : r_tx;
`else
    assign w_rx_in = rx;
    assign tx      = r_tx;
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t            r_rx_state;
    logic [1:0]           r_rx_sync;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [3:0]           r_rx_tick_cnt;
    logic [2:0]           r_rx_bit_idx;
    logic                 r_rx_s7;
    logic                 r_rx_s8;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_ferr_out;
    logic                 r_rx_perr_out;
    logic                 w_rx_s;
    logic                 w_rx_tick;
    logic                 w_rx_clr;
    logic                 w_rx_vote;
    logic                 w_rx_at_vote;
    logic                 w_rx_bit_end;
    logic                 w_rx_par_exp;
    logic                 w_rx_ferr_now;

    assign w_rx_s        = r_rx_sync[1];
    assign w_rx_clr      = (r_rx_state == RX_IDLE) && !w_rx_s;
    assign w_rx_vote     = (r_rx_s7 & r_rx_s8) | (r_rx_s7 & w_rx_s) | (r_rx_s8 & w_rx_s);
    assign w_rx_at_vote  = w_rx_tick && (r_rx_tick_cnt == 4'(SAMPLE_T2));
    assign w_rx_bit_end  = w_rx_tick && (r_rx_tick_cnt == C_LAST_TICK);
    assign w_rx_par_exp  = (^r_rx_shift) ^ C_ODD;
    assign w_rx_ferr_now = r_rx_ferr | !w_rx_vote;

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_ferr_out;
    assign rx_parity_err = r_rx_perr_out;

    uart_tick_gen #(.DIV(OS_DIV)) u_rx_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_rx_clr),
        .tick (w_rx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], w_rx_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_shift    <= '0;
            r_rx_tick_cnt <= '0;
            r_rx_bit_idx  <= '0;
            r_rx_s7       <= 1'b1;
            r_rx_s8       <= 1'b1;
            r_rx_perr     <= 1'b0;
            r_rx_ferr     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_ferr_out <= 1'b0;
            r_rx_perr_out <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_rx_tick_cnt <= '0;
                        r_rx_bit_idx  <= '0;
                        r_rx_perr     <= 1'b0;
                        r_rx_ferr     <= 1'b0;
                        r_rx_state    <= RX_START;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
                        if (r_rx_tick_cnt == 4'(SAMPLE_T0)) r_rx_s7 <= w_rx_s;
                        if (r_rx_tick_cnt == 4'(SAMPLE_T1)) r_rx_s8 <= w_rx_s;
                    end
                    if (w_rx_at_vote) begin
                        case (r_rx_state)
                            RX_START: begin
                                if (w_rx_vote) r_rx_state <= RX_IDLE;
                            end
                            RX_DATA: begin
                                r_rx_shift <= {w_rx_vote, r_rx_shift[DATA_BITS-1:1]};
                            end
                            RX_PARITY: begin
                                r_rx_perr <= (w_rx_vote != w_rx_par_exp);
                            end
                            default: begin
                                // Last stop bit: deliver now so the rest of the bit overlaps IDLE.
                                if (r_rx_bit_idx == C_LAST_STOP) begin
                                    r_rx_valid    <= 1'b1;
                                    r_rx_data     <= r_rx_shift;
                                    r_rx_ferr_out <= w_rx_ferr_now;
                                    r_rx_perr_out <= r_rx_perr;
                                    r_rx_state    <= w_rx_ferr_now ? RX_WAIT_HIGH : RX_IDLE;
                                end else begin
                                    r_rx_ferr <= w_rx_ferr_now;
                                end
                            end
                        endcase
                    end
                    if (w_rx_bit_end) begin
                        case (r_rx_state)
                            RX_START: begin
                                r_rx_bit_idx <= '0;
                                r_rx_state   <= RX_DATA;
                            end
                            RX_DATA: begin
                                if (r_rx_bit_idx == C_LAST_DATA) begin
                                    r_rx_bit_idx <= '0;
                                    r_rx_state   <= C_HAS_PAR ? RX_PARITY : RX_STOP;
                                end else begin
                                    r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                                end
                            end
                            RX_PARITY: begin
                                r_rx_bit_idx <= '0;
                                r_rx_state   <= RX_STOP;
                            end
                            default: begin
                                r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
